// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared state encodings and constants for the RAM port arbiter
package ram_port_arbiter_pkg;

    localparam int ARB_STATE_BUS          = 2;
    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    localparam logic        TRUE      = 1'b1;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [ARB_STATE_BUS-1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_D = 2'd1,
        ARB_BUSY_F = 2'd2,
        ARB_RESP   = 2'd3
    } arb_state_t;

    function automatic logic is_busy(input arb_state_t s);
        return (s == ARB_BUSY_D) || (s == ARB_BUSY_F);
    endfunction

endpackage

// File: rtl/ram_port_arbiter_watchdog.sv
// rtl/ram_port_arbiter_watchdog.sv - clear-able transaction watchdog with terminal-count flag
module arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_terminal
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Saturates at the terminal value so a stuck enable can never wrap back to a benign count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && !o_terminal) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_terminal = (r_count == TERMINAL);

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - single RAM port shared between instruction fetch and load/store
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_flush,
    output logic              fetch_ack,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              data_req,
    input  logic              data_write_en,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [3:0]        data_write_sel,
    input  logic [DATA_W-1:0] data_write_data,
    output logic              data_ack,
    output logic [DATA_W-1:0] data_rdata,
    output logic              bus_err,
    output logic              ram_en,
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_write_sel,
    output logic [DATA_W-1:0] ram_write_data,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready,
    output logic              stall_req
);

    arb_state_t r_state;
    arb_state_t w_next_state;

    logic w_load_d;
    logic w_load_f;
    logic w_finish;
    logic w_busy;
    logic w_wd_terminal;
    logic w_fetch_dropped;
    logic [DATA_W-1:0] w_rd_word;

    logic              r_ram_en;
    logic              r_ram_write_en;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [3:0]        r_ram_write_sel;
    logic [DATA_W-1:0] r_ram_write_data;

    logic              r_fetch_ack;
    logic [DATA_W-1:0] r_fetch_rdata;
    logic              r_data_ack;
    logic [DATA_W-1:0] r_data_rdata;
    logic              r_bus_err;
    logic              r_flush_pending;

    assign w_busy = is_busy(r_state);

    arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_load_d | w_load_f),
        .i_inc     (w_busy),
        .o_terminal(w_wd_terminal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Data wins over fetch; requests are only looked at in IDLE so a held req is served once.
    always_comb begin
        w_next_state = r_state;
        w_load_d     = 1'b0;
        w_load_f     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (data_req) begin
                    w_next_state = ARB_BUSY_D;
                    w_load_d     = 1'b1;
                end else if (fetch_req) begin
                    w_next_state = ARB_BUSY_F;
                    w_load_f     = 1'b1;
                end
            end
            ARB_BUSY_D, ARB_BUSY_F: begin
                if (ram_ready || w_wd_terminal) begin
                    w_next_state = ARB_RESP;
                    w_finish     = 1'b1;
                end
            end
            ARB_RESP: begin
                w_next_state = ARB_IDLE;
            end
            default: begin
                w_next_state = ARB_IDLE;
            end
        endcase
    end

    // A timeout completes with a zero word; ready wins if both happen together.
    assign w_rd_word       = ram_ready ? ram_rdata : '0;
    assign w_fetch_dropped = r_flush_pending | fetch_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ram_en         <= 1'b0;
            r_ram_write_en   <= 1'b0;
            r_ram_addr       <= '0;
            r_ram_write_sel  <= '0;
            r_ram_write_data <= '0;
        end else if (w_load_d) begin
            r_ram_en         <= TRUE;
            r_ram_write_en   <= data_write_en;
            r_ram_addr       <= data_addr;
            r_ram_write_sel  <= data_write_sel;
            r_ram_write_data <= data_write_data;
        end else if (w_load_f) begin
            r_ram_en         <= TRUE;
            r_ram_write_en   <= 1'b0;
            r_ram_addr       <= fetch_addr;
            r_ram_write_sel  <= '0;
            r_ram_write_data <= '0;
        end else if (w_finish) begin
            r_ram_en         <= 1'b0;
            r_ram_write_en   <= 1'b0;
            r_ram_addr       <= '0;
            r_ram_write_sel  <= '0;
            r_ram_write_data <= '0;
        end
    end

    // Response registers are loaded on the edge into RESP and cleared on every other edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_ack   <= 1'b0;
            r_fetch_rdata <= '0;
            r_data_ack    <= 1'b0;
            r_data_rdata  <= '0;
            r_bus_err     <= 1'b0;
        end else begin
            r_fetch_ack   <= 1'b0;
            r_fetch_rdata <= '0;
            r_data_ack    <= 1'b0;
            r_data_rdata  <= '0;
            r_bus_err     <= 1'b0;
            if (w_finish) begin
                if (r_state == ARB_BUSY_D) begin
                    r_data_ack   <= TRUE;
                    r_data_rdata <= w_rd_word;
                    r_bus_err    <= ~ram_ready;
                end else if (!w_fetch_dropped) begin
                    r_fetch_ack   <= TRUE;
                    r_fetch_rdata <= w_rd_word;
                    r_bus_err     <= ~ram_ready;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flush_pending <= 1'b0;
        end else if (r_state == ARB_RESP) begin
            r_flush_pending <= 1'b0;
        end else if (r_state == ARB_BUSY_F && fetch_flush) begin
            r_flush_pending <= TRUE;
        end
    end

    assign fetch_ack      = r_fetch_ack;
    assign fetch_rdata    = r_fetch_rdata;
    assign data_ack       = r_data_ack;
    assign data_rdata     = r_data_rdata;
    assign bus_err        = r_bus_err;
    assign ram_en         = r_ram_en;
    assign ram_write_en   = r_ram_write_en;
    assign ram_addr       = r_ram_addr;
    assign ram_write_sel  = r_ram_write_sel;
    assign ram_write_data = r_ram_write_data;

    assign stall_req = rst & ((fetch_req & ~r_fetch_ack & ~r_flush_pending) |
                              (data_req & ~r_data_ack));

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req, fetch_flush, data_req, data_write_en, ram_ready;
    logic [31:0] fetch_addr, data_addr, data_write_data, ram_rdata;
    logic [3:0]  data_write_sel;
    logic        fetch_ack, data_ack, bus_err, ram_en, ram_write_en, stall_req;
    logic [31:0] fetch_rdata, data_rdata, ram_addr, ram_write_data;
    logic [3:0]  ram_write_sel;

    int n_pass  = 0;
    int n_total = 0;

    ram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
        .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata),
        .data_req(data_req), .data_write_en(data_write_en), .data_addr(data_addr),
        .data_write_sel(data_write_sel), .data_write_data(data_write_data),
        .data_ack(data_ack), .data_rdata(data_rdata), .bus_err(bus_err),
        .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
        .ram_write_sel(ram_write_sel), .ram_write_data(ram_write_data),
        .ram_rdata(ram_rdata), .ram_ready(ram_ready), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // RAM responder: answers rdy_delay cycles after ram_en rises, never if rdy_delay < 0.
    int          rdy_delay = 0;
    logic [31:0] rd_word   = '0;
    int          rcnt      = 0;
    always @(posedge clk) begin
        #1;
        if (rst && ram_en) begin
            if (rdy_delay >= 0 && rcnt == rdy_delay) begin
                ram_ready = 1'b1;
                ram_rdata = rd_word;
            end else begin
                ram_ready = 1'b0;
                ram_rdata = 32'hBAD0_0000 | rcnt;
            end
            rcnt++;
        end else begin
            ram_ready = 1'b0;
            ram_rdata = 32'hBAD0_FFFF;
            rcnt = 0;
        end
    end

    // Transaction-level model: phase 0 waiting, 1 RAM in use, 2 answering.
    int          phase = 0, waited = 0;
    bit          for_data = 0, flushed = 0;
    logic        m_we = 0;
    logic [31:0] m_addr = '0, m_wd = '0;
    logic [3:0]  m_sel = '0;
    logic        e_dack = 0, e_fack = 0, e_err = 0;
    logic [31:0] e_drd = '0, e_frd = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase = 0; waited = 0; flushed = 0;
            e_dack = 0; e_fack = 0; e_err = 0; e_drd = '0; e_frd = '0;
        end else begin
            case (phase)
                0: begin
                    waited = 0;
                    if (data_req) begin
                        phase = 1; for_data = 1;
                        m_we = data_write_en; m_addr = data_addr;
                        m_sel = data_write_sel; m_wd = data_write_data;
                    end else if (fetch_req) begin
                        phase = 1; for_data = 0;
                        m_we = 0; m_addr = fetch_addr; m_sel = '0; m_wd = '0;
                    end
                end
                1: begin
                    if (!for_data && fetch_flush) flushed = 1;
                    if (ram_ready || waited == TO - 1) begin
                        phase = 2;
                        if (for_data) begin
                            e_dack = 1; e_drd = ram_ready ? ram_rdata : '0; e_err = !ram_ready;
                        end else if (!flushed) begin
                            e_fack = 1; e_frd = ram_ready ? ram_rdata : '0; e_err = !ram_ready;
                        end
                    end else begin
                        waited++;
                    end
                end
                default: begin
                    phase = 0; flushed = 0;
                    e_dack = 0; e_fack = 0; e_err = 0; e_drd = '0; e_frd = '0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        logic busy;
        logic exp_stall;
        busy      = (phase == 1);
        exp_stall = rst && ((fetch_req && !e_fack && !flushed) || (data_req && !e_dack));
        chk("ram_en", ram_en, busy);
        chk("ram_write_en", ram_write_en, busy ? m_we : 1'b0);
        chk("ram_addr", ram_addr, busy ? m_addr : 32'h0);
        chk("ram_write_sel", ram_write_sel, busy ? m_sel : 4'h0);
        chk("ram_write_data", ram_write_data, busy ? m_wd : 32'h0);
        chk("data_ack", data_ack, e_dack);
        chk("data_rdata", data_rdata, e_drd);
        chk("fetch_ack", fetch_ack, e_fack);
        chk("fetch_rdata", fetch_rdata, e_frd);
        chk("bus_err", bus_err, e_err);
        chk("stall_req", stall_req, exp_stall);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1;
        fetch_req = 0; fetch_flush = 0; fetch_addr = '0;
        data_req = 0; data_write_en = 0; data_addr = '0; data_write_sel = '0; data_write_data = '0;
        ram_ready = 0; ram_rdata = '0;
        #1 rst = 1'b0;
        fetch_req = 1'b1;
        #6;
        chk("reset ram_en", ram_en, 1'b0);
        chk("reset fetch_ack", fetch_ack, 1'b0);
        chk("reset stall_req", stall_req, 1'b0);
        fetch_req = 1'b0;
        tick();
        rst = 1'b1;
        idle(2);

        // Fetch only, ready in first RAM cycle
        fetch_req = 1; fetch_addr = 32'h100; rd_word = 32'h2402_0005; rdy_delay = 0;
        tick();
        chk("t1 ram_en c1", ram_en, 1'b1);
        chk("t1 ram_addr c1", ram_addr, 32'h100);
        chk("t1 stall c1", stall_req, 1'b1);
        tick();
        chk("t1 fetch_ack c2", fetch_ack, 1'b1);
        chk("t1 fetch_rdata c2", fetch_rdata, 32'h2402_0005);
        chk("t1 stall c2", stall_req, 1'b0);
        fetch_req = 0;
        tick();
        chk("t1 fetch_ack c3", fetch_ack, 1'b0);
        idle(2);

        // Simultaneous: store first, then fetch
        data_req = 1; data_write_en = 1; data_addr = 32'h200; data_write_sel = 4'b0011;
        data_write_data = 32'hDEAD_BEEF; fetch_req = 1; fetch_addr = 32'h104;
        rd_word = 32'h1111_1111; rdy_delay = 0;
        tick();
        chk("t2 store en", ram_en, 1'b1);
        chk("t2 store we", ram_write_en, 1'b1);
        chk("t2 store addr", ram_addr, 32'h200);
        chk("t2 store sel", ram_write_sel, 4'b0011);
        chk("t2 store wdata", ram_write_data, 32'hDEAD_BEEF);
        tick();
        chk("t2 data_ack", data_ack, 1'b1);
        chk("t2 fetch_ack early", fetch_ack, 1'b0);
        chk("t2 ram_en in resp", ram_en, 1'b0);
        data_req = 0; data_write_en = 0;
        tick();
        chk("t2 gap ram_en", ram_en, 1'b0);
        tick();
        chk("t2 fetch addr", ram_addr, 32'h104);
        chk("t2 fetch we", ram_write_en, 1'b0);
        tick();
        chk("t2 fetch_ack", fetch_ack, 1'b1);
        chk("t2 fetch_rdata", fetch_rdata, 32'h1111_1111);
        fetch_req = 0;
        idle(2);

        // Wait states
        data_req = 1; data_addr = 32'h300; rd_word = 32'hCAFE_F00D; rdy_delay = 5;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t3 ram_en held", ram_en, 1'b1);
            chk("t3 ram_addr held", ram_addr, 32'h300);
            chk("t3 stall held", stall_req, 1'b1);
        end
        tick();
        chk("t3 data_ack c7", data_ack, 1'b1);
        chk("t3 data_rdata", data_rdata, 32'hCAFE_F00D);
        chk("t3 bus_err", bus_err, 1'b0);
        data_req = 0;
        idle(2);

        // Timeout
        data_req = 1; data_addr = 32'h400; rdy_delay = -1;
        for (int i = 0; i < TO; i++) begin
            tick();
            chk("t4 ram_en busy", ram_en, 1'b1);
        end
        tick();
        chk("t4 data_ack", data_ack, 1'b1);
        chk("t4 bus_err", bus_err, 1'b1);
        chk("t4 data_rdata", data_rdata, 32'h0);
        data_req = 0;
        idle(2);

        // Flush during fetch, then a normal fetch
        fetch_req = 1; fetch_addr = 32'h500; rd_word = 32'h55; rdy_delay = 2;
        tick();
        fetch_flush = 1; fetch_addr = 32'h600;
        tick();
        fetch_flush = 0;
        chk("t5 stall after flush", stall_req, 1'b0);
        chk("t5 ram still busy", ram_en, 1'b1);
        tick();
        rd_word = 32'h66; rdy_delay = 0;
        tick();
        chk("t5 flushed fetch_ack", fetch_ack, 1'b0);
        chk("t5 flushed rdata", fetch_rdata, 32'h0);
        tick();
        chk("t5 stall back", stall_req, 1'b1);
        tick();
        chk("t5 refetch addr", ram_addr, 32'h600);
        tick();
        chk("t5 refetch ack", fetch_ack, 1'b1);
        chk("t5 refetch rdata", fetch_rdata, 32'h66);
        fetch_req = 0;
        idle(2);

        // Reset in BUSY_D, held request restarts
        data_req = 1; data_addr = 32'h700; rdy_delay = -1;
        tick();
        chk("t6 ram_en before", ram_en, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("t6 ram_en async", ram_en, 1'b0);
        chk("t6 stall in reset", stall_req, 1'b0);
        rdy_delay = 0; rd_word = 32'h77;
        tick();
        chk("t6 no ack in reset", data_ack, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        chk("t6 restart ram_en", ram_en, 1'b1);
        chk("t6 restart addr", ram_addr, 32'h700);
        tick();
        chk("t6 restart ack", data_ack, 1'b1);
        chk("t6 restart rdata", data_rdata, 32'h77);
        data_req = 0;
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
